// File: rtl/pc_fetch.sv
// pc_fetch
//   Fetch-stage PC register and instruction-fetch controller. It sits directly
//   after the PC-select mux, holds the current fetch PC and keeps at most one
//   instruction-memory request outstanding. The 32-bit response goes into a
//   one-entry buffer that is handed to decode as {pc, inst} over valid/ready.
//   A redirect reloads the PC and squashes any in-flight or buffered fetch.
//
// Ports
//   clock, reset        system clock, asynchronous active-high reset
//   next_pc, redirect   target PC and load strobe from the PC-select mux
//   imem_req_*          request channel (valid/ready), imem_addr = fetch PC
//   imem_resp_*         response channel (valid only, no backpressure)
//   id_valid/id_ready   handshake to decode
//   id_pc, id_inst      buffered PC and instruction presented to decode
//   id_misalign         instruction-address-misaligned flag
//
// Build option
//   PC_MISALIGN_CHECK_EN: a redirect to an address with next_pc[1:0] != 0
//   skips the memory and presents a NOP flagged id_misalign=1 to decode.
//   When undefined, id_misalign is always 0 and next_pc[1:0] is cleared on
//   every PC load.
//
// state  | meaning
// S_REQ  | request presented at pc_q, waiting for imem_req_ready
// S_WAIT | one request outstanding, waiting for imem_resp_valid
// S_FULL | buffer holds an entry for decode, waiting for id_ready
module pc_fetch #(
    parameter int              PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(64'h0000_0000_8000_0000)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [PC_W-1:0] next_pc,
    input  logic            redirect,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [PC_W-1:0] id_pc,
    output logic [31:0]     id_inst,
    output logic            id_misalign
);

    localparam logic [31:0]     NOP_INST   = 32'h0000_0013;
    localparam logic [PC_W-1:0] PC_STEP    = PC_W'(4);
    localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_FULL = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] buf_pc_q, buf_pc_d;
    logic [31:0]     buf_inst_q, buf_inst_d;
    logic            buf_mis_q, buf_mis_d;
    logic            kill_q, kill_d;
    logic [PC_W-1:0] load_pc;
    logic            req_fire;

`ifdef PC_MISALIGN_CHECK_EN
    // Misaligned targets are handled by the override below, so the raw
    // target is loaded as-is.
    assign load_pc = next_pc;
    // A squashed response can still be in flight after a misaligned redirect
    // left S_WAIT; no new request goes out until it has been drained.
    assign imem_req_valid = (state_q == S_REQ) && !redirect && !kill_q;
`else
    assign load_pc = next_pc & ALIGN_MASK;
    assign imem_req_valid = (state_q == S_REQ) && !redirect;
`endif

    assign req_fire    = imem_req_valid && imem_req_ready;
    assign imem_addr   = pc_q;
    assign id_valid    = (state_q == S_FULL) && !redirect;
    assign id_pc       = buf_pc_q;
    assign id_inst     = buf_inst_q;
    assign id_misalign = buf_mis_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        kill_d     = kill_q;
        buf_pc_d   = buf_pc_q;
        buf_inst_d = buf_inst_q;
        buf_mis_d  = buf_mis_q;

`ifdef PC_MISALIGN_CHECK_EN
        // Drain of a squashed response outside S_WAIT.
        if (kill_q && imem_resp_valid && (state_q != S_WAIT)) begin
            kill_d = 1'b0;
        end
`endif

        case (state_q)
            S_REQ: begin
                if (redirect) begin
                    pc_d = load_pc;
                end else if (req_fire) begin
                    buf_pc_d = pc_q;
                    pc_d     = pc_q + PC_STEP;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    if (kill_q || redirect) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                        if (redirect) begin
                            pc_d = load_pc;
                        end
                    end else begin
                        buf_inst_d = imem_resp_data;
                        buf_mis_d  = 1'b0;
                        state_d    = S_FULL;
                    end
                end else if (redirect) begin
                    // Response still owed by memory; mark it to be dropped.
                    pc_d   = load_pc;
                    kill_d = 1'b1;
                end
            end
            S_FULL: begin
                if (redirect) begin
                    pc_d    = load_pc;
                    state_d = S_REQ;
                end else if (id_ready) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

`ifdef PC_MISALIGN_CHECK_EN
        if (redirect && (next_pc[1:0] != 2'b00)) begin
            state_d    = S_FULL;
            pc_d       = next_pc;
            buf_pc_d   = next_pc;
            buf_inst_d = NOP_INST;
            buf_mis_d  = 1'b1;
            // Still owed a response if one was outstanding and it does not
            // arrive this very cycle.
            kill_d     = ((state_q == S_WAIT) || kill_q) && !imem_resp_valid;
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            kill_q     <= 1'b0;
            buf_pc_q   <= '0;
            buf_inst_q <= NOP_INST;
            buf_mis_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            kill_q     <= kill_d;
            buf_pc_q   <= buf_pc_d;
            buf_inst_q <= buf_inst_d;
            buf_mis_q  <= buf_mis_d;
        end
    end

endmodule
